// File: rtl/ili9341_spi_receiver_pkg.sv
// ili9341_defines
// Shared ILI9341 definitions: command opcodes understood by the receiver and
// the RGB565 pixel layout used on the framebuffer write port.
// No ports (package).

package ili9341_defines;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef struct packed {
        logic [4:0] red;
        logic [5:0] green;
        logic [4:0] blue;
    } ILI9341_color_t;

endpackage

// File: rtl/ili9341_spi_receiver_byte_rx.sv
// spi_byte_receiver
// Brings the SPI pins into the clk domain through 2-FF synchronizers, detects
// spi_clk rising edges and assembles MSB-first bytes. A byte appears on
// byte_valid three clk cycles after the spi_clk rising edge of its bit 0.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   soft_clr        clears the bit count only (synchronizers keep running)
//   spi_csb, spi_clk, spi_mosi, data_commandb   raw SPI pins
//   byte_valid      one-cycle strobe with byte_data / byte_dc
//   byte_data       received byte
//   byte_dc         data_commandb as sampled with bit 0

module spi_byte_receiver (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_clr,
    input  logic       spi_csb,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       data_commandb,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc
);

    logic [1:0] r_csb_sync;
    logic [1:0] r_sclk_sync;
    logic [1:0] r_mosi_sync;
    logic [1:0] r_dc_sync;
    logic       r_sclk_prev;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic       w_rise;

    assign w_rise = r_sclk_sync[1] & ~r_sclk_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_csb_sync  <= 2'b11;
            r_sclk_sync <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_dc_sync   <= 2'b00;
            r_sclk_prev <= 1'b0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            byte_valid  <= 1'b0;
            byte_data   <= 8'd0;
            byte_dc     <= 1'b0;
        end else begin
            r_csb_sync  <= {r_csb_sync[0], spi_csb};
            r_sclk_sync <= {r_sclk_sync[0], spi_clk};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
            r_dc_sync   <= {r_dc_sync[0], data_commandb};
            r_sclk_prev <= r_sclk_sync[1];
            byte_valid  <= 1'b0;
            // Deselect drops any partial byte; the next select starts at bit 7.
            if (soft_clr || r_csb_sync[1]) begin
                r_bit_cnt <= 3'd0;
            end else if (w_rise) begin
                if (r_bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {r_shift, r_mosi_sync[1]};
                    byte_dc    <= r_dc_sync[1];
                    r_bit_cnt  <= 3'd0;
                end else begin
                    r_shift   <= {r_shift[5:0], r_mosi_sync[1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ili9341_spi_receiver.sv
// ili9341_spi_receiver
// Receives the ILI9341 SPI command/data stream and turns RAMWR pixel data into
// framebuffer writes at y*DISPLAY_WIDTH+x inside the CASET/PASET window.
// Optional build macro ILI9341_RX_BOUNDS_CHECK_EN: rejects out-of-range or
// inverted windows and raises the sticky error flag; without it window values
// are truncated to the pointer width and error stays 0.
// Ports:
//   clk, rst                      system clock, synchronous active-high reset
//   spi_csb/clk/mosi, data_commandb   SPI slave inputs (mode 0, MSB first)
//   spi_miso                      tied 0
//   fb_wr_ena/addr/data           framebuffer write port (RGB565)
//   cmd_valid, cmd_byte           command strobe and last opcode
//   sleep_out, display_on         SLPOUT / DISPON status
//   error                         sticky window error
//
// state    | meaning
// S_IDLE   | after reset or a status command, data bytes ignored
// S_CASET  | collecting xs/xe parameter bytes
// S_PASET  | collecting ys/ye parameter bytes
// S_RAMWR  | data bytes are pixel halves, high byte first
// S_IGNORE | unsupported command, its parameters ignored

module ili9341_spi_receiver
    import ili9341_defines::*;
#(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_csb,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    input  logic                      data_commandb,
    output logic                      spi_miso,
    output logic                      fb_wr_ena,
    output logic [$clog2(VRAM_L)-1:0] fb_wr_addr,
    output logic [15:0]               fb_wr_data,
    output logic                      cmd_valid,
    output logic [7:0]                cmd_byte,
    output logic                      sleep_out,
    output logic                      display_on,
    output logic                      error
);

    localparam int AW = $clog2(VRAM_L);
    localparam int XW = $clog2(DISPLAY_WIDTH);
    localparam int YW = $clog2(DISPLAY_HEIGHT);
    localparam logic [15:0]   W_LIM = 16'(DISPLAY_WIDTH);
    localparam logic [15:0]   H_LIM = 16'(DISPLAY_HEIGHT);
    localparam logic [XW-1:0] X_MAX = XW'(DISPLAY_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(DISPLAY_HEIGHT - 1);
`ifdef ILI9341_RX_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_CASET, S_PASET, S_RAMWR, S_IGNORE} state_t;

    state_t         r_state, w_state_nxt;
    logic           w_byte_valid, w_byte_dc, w_cmd, w_dat, w_swreset;
    logic [7:0]     w_byte_data;
    logic [2:0]     r_param_cnt;
    logic [7:0]     r_p0, r_p1, r_p2;
    logic [15:0]    w_start, w_end;
    logic           w_x_bad, w_y_bad;
    logic [XW-1:0]  r_xs, r_xe, r_x;
    logic [YW-1:0]  r_ys, r_ye, r_y;
    logic           r_hi_valid;
    logic [7:0]     r_hi_byte;
    logic [AW-1:0]  w_addr;
    logic           r_wr_ena, r_cmd_valid, r_sleep, r_disp, r_error;
    logic [AW-1:0]  r_wr_addr;
    ILI9341_color_t r_wr_data;
    logic [7:0]     r_cmd_byte;

    spi_byte_receiver u_byte_rx (
        .clk           (clk),
        .rst           (rst),
        .soft_clr      (w_swreset),
        .spi_csb       (spi_csb),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .data_commandb (data_commandb),
        .byte_valid    (w_byte_valid),
        .byte_data     (w_byte_data),
        .byte_dc       (w_byte_dc)
    );

    assign w_cmd     = w_byte_valid & ~w_byte_dc;
    assign w_dat     = w_byte_valid & w_byte_dc;
    assign w_swreset = w_cmd && (w_byte_data == CMD_SWRESET);

    // Fourth parameter byte completes the window: {b0,b1} start, {b2,b3} end.
    assign w_start = {r_p0, r_p1};
    assign w_end   = {r_p2, w_byte_data};
    assign w_x_bad = BOUNDS_EN && ((w_end >= W_LIM) || (w_start > w_end));
    assign w_y_bad = BOUNDS_EN && ((w_end >= H_LIM) || (w_start > w_end));

    assign w_addr = AW'(r_y) * AW'(DISPLAY_WIDTH) + AW'(r_x);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cmd) begin
            case (w_byte_data)
                CMD_CASET: w_state_nxt = S_CASET;
                CMD_PASET: w_state_nxt = S_PASET;
                CMD_RAMWR: w_state_nxt = S_RAMWR;
                CMD_SWRESET, CMD_SLPOUT, CMD_DISPON, CMD_DISPOFF: w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IGNORE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_swreset) begin
            r_param_cnt <= 3'd0;
            r_p0        <= 8'd0;
            r_p1        <= 8'd0;
            r_p2        <= 8'd0;
            r_xs        <= '0;
            r_xe        <= X_MAX;
            r_ys        <= '0;
            r_ye        <= Y_MAX;
            r_x         <= '0;
            r_y         <= '0;
            r_hi_valid  <= 1'b0;
            r_hi_byte   <= 8'd0;
            r_wr_ena    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_byte  <= 8'd0;
            r_sleep     <= 1'b0;
            r_disp      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_wr_ena    <= 1'b0;
            if (w_cmd) begin
                r_cmd_valid <= 1'b1;
                r_cmd_byte  <= w_byte_data;
                r_param_cnt <= 3'd0;
                r_hi_valid  <= 1'b0;
                case (w_byte_data)
                    CMD_SLPOUT:  r_sleep <= 1'b1;
                    CMD_DISPON:  r_disp  <= 1'b1;
                    CMD_DISPOFF: r_disp  <= 1'b0;
                    CMD_RAMWR: begin
                        r_x <= r_xs;
                        r_y <= r_ys;
                    end
                    default: ;
                endcase
            end else if (w_dat) begin
                case (r_state)
                    S_CASET, S_PASET: begin
                        if (r_param_cnt != 3'd4) begin
                            r_param_cnt <= r_param_cnt + 3'd1;
                            case (r_param_cnt)
                                3'd0: r_p0 <= w_byte_data;
                                3'd1: r_p1 <= w_byte_data;
                                3'd2: r_p2 <= w_byte_data;
                                default: begin
                                    if (r_state == S_CASET) begin
                                        if (w_x_bad) begin
                                            r_error <= 1'b1;
                                        end else begin
                                            r_xs <= w_start[XW-1:0];
                                            r_xe <= w_end[XW-1:0];
                                        end
                                    end else begin
                                        if (w_y_bad) begin
                                            r_error <= 1'b1;
                                        end else begin
                                            r_ys <= w_start[YW-1:0];
                                            r_ye <= w_end[YW-1:0];
                                        end
                                    end
                                end
                            endcase
                        end
                    end
                    S_RAMWR: begin
                        if (!r_hi_valid) begin
                            r_hi_valid <= 1'b1;
                            r_hi_byte  <= w_byte_data;
                        end else begin
                            r_hi_valid <= 1'b0;
                            r_wr_ena   <= 1'b1;
                            r_wr_addr  <= w_addr;
                            r_wr_data  <= ILI9341_color_t'({r_hi_byte, w_byte_data});
                            if (r_x == r_xe) begin
                                r_x <= r_xs;
                                r_y <= (r_y == r_ye) ? r_ys : r_y + 1'b1;
                            end else begin
                                r_x <= r_x + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign spi_miso   = 1'b0;
    assign fb_wr_ena  = r_wr_ena;
    assign fb_wr_addr = r_wr_addr;
    assign fb_wr_data = r_wr_data;
    assign cmd_valid  = r_cmd_valid;
    assign cmd_byte   = r_cmd_byte;
    assign sleep_out  = r_sleep;
    assign display_on = r_disp;
    assign error      = r_error;

endmodule

// File: tb/tb_ili9341_spi_receiver.sv
// tb_ili9341_spi_receiver
// Directed bench for ili9341_spi_receiver: expected commands and framebuffer
// writes are queued as stimulus is driven and compared as the DUT emits them.
// Honours ILI9341_RX_BOUNDS_CHECK_EN for the window-error scenario.

module tb_ili9341_spi_receiver;

    localparam int W  = 240;
    localparam int H  = 320;
    localparam int VL = W * H;
    localparam int AW = $clog2(VL);

    logic          clk = 1'b0;
    logic          rst;
    logic          spi_csb, spi_clk, spi_mosi, data_commandb;
    logic          spi_miso, fb_wr_ena, cmd_valid, sleep_out, display_on, error;
    logic [AW-1:0] fb_wr_addr;
    logic [15:0]   fb_wr_data;
    logic [7:0]    cmd_byte;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] cmd_q[$];
    time        t_rise = 0;

    always #5 clk = ~clk;

    ili9341_spi_receiver #(
        .DISPLAY_WIDTH  (W),
        .DISPLAY_HEIGHT (H),
        .VRAM_L         (VL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .spi_csb       (spi_csb),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .data_commandb (data_commandb),
        .spi_miso      (spi_miso),
        .fb_wr_ena     (fb_wr_ena),
        .fb_wr_addr    (fb_wr_addr),
        .fb_wr_data    (fb_wr_data),
        .cmd_valid     (cmd_valid),
        .cmd_byte      (cmd_byte),
        .sleep_out     (sleep_out),
        .display_on    (display_on),
        .error         (error)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: compare every strobe against the queued expectation.
    // A strobe shows up 4 clk after the spi_clk rise of bit 0 (3 to the byte,
    // 1 registered output stage), i.e. 40 ns at the sampling negedge.
    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            if (cmd_q.size() == 0) begin
                check("cmd_unexpected", 32'(cmd_byte), 32'hFFFF_FFFF);
            end else begin
                check("cmd_byte", 32'(cmd_byte), 32'(cmd_q.pop_front()));
            end
            check("cmd_latency", 32'($time - t_rise), 32'd40);
        end
        if (fb_wr_ena === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 32'(fb_wr_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", 32'(fb_wr_addr), 32'(e.addr));
                check("wr_data", 32'(fb_wr_data), 32'(e.data));
            end
            check("wr_latency", 32'($time - t_rise), 32'd40);
        end
    end

    task automatic send_bits(input logic dc, input logic [7:0] b, input int nbits);
        data_commandb = dc;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = b[i];
            repeat (4) @(negedge clk);
            spi_clk = 1'b1;
            t_rise  = $time;
            repeat (4) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        cmd_q.push_back(b);
        send_bits(1'b0, b, 8);
    endtask

    task automatic send_data(input logic [7:0] b);
        send_bits(1'b1, b, 8);
    endtask

    task automatic send_pixel(input logic [AW-1:0] addr, input logic [15:0] px);
        wr_t e;
        e.addr = addr;
        e.data = px;
        wr_q.push_back(e);
        send_data(px[15:8]);
        send_data(px[7:0]);
    endtask

    task automatic send_swreset();
        // SWRESET clears every output, cmd_valid included, so nothing is queued.
        send_bits(1'b0, 8'h01, 8);
    endtask

    task automatic drain(input string tag);
        repeat (8) @(negedge clk);
        check({tag, "_cmd_drain"}, 32'(cmd_q.size()), 32'd0);
        check({tag, "_wr_drain"}, 32'(wr_q.size()), 32'd0);
        cmd_q.delete();
        wr_q.delete();
    endtask

    initial begin
        rst           = 1'b1;
        spi_csb       = 1'b1;
        spi_clk       = 1'b0;
        spi_mosi      = 1'b0;
        data_commandb = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_miso",       32'(spi_miso),   32'd0);
        check("rst_wr_ena",     32'(fb_wr_ena),  32'd0);
        check("rst_wr_addr",    32'(fb_wr_addr), 32'd0);
        check("rst_wr_data",    32'(fb_wr_data), 32'd0);
        check("rst_cmd_valid",  32'(cmd_valid),  32'd0);
        check("rst_cmd_byte",   32'(cmd_byte),   32'd0);
        check("rst_sleep_out",  32'(sleep_out),  32'd0);
        check("rst_display_on", 32'(display_on), 32'd0);
        check("rst_error",      32'(error),      32'd0);

        rst     = 1'b0;
        spi_csb = 1'b0;
        repeat (4) @(negedge clk);

        // SLPOUT, DISPON, then DISPOFF
        send_cmd(8'h11);
        send_cmd(8'h29);
        repeat (6) @(negedge clk);
        check("sleep_out",  32'(sleep_out),  32'd1);
        check("display_on", 32'(display_on), 32'd1);
        check("cmd_byte_29", 32'(cmd_byte),  32'h29);
        send_cmd(8'h28);
        repeat (6) @(negedge clk);
        check("display_off", 32'(display_on), 32'd0);
        drain("status");

        // 2x2 window at x 10..11, y 5..6 with wrap back to window start
        send_cmd(8'h2A);
        send_data(8'h00); send_data(8'h0A); send_data(8'h00); send_data(8'h0B);
        send_data(8'h77);
        send_cmd(8'h2B);
        send_data(8'h00); send_data(8'h05); send_data(8'h00); send_data(8'h06);
        send_cmd(8'h2C);
        send_pixel(17'd1210, 16'hF800);
        send_pixel(17'd1211, 16'h07E0);
        send_pixel(17'd1450, 16'h001F);
        send_pixel(17'd1451, 16'hFFFF);
        send_pixel(17'd1210, 16'h1234);
        drain("window");

        // SWRESET clears outputs and restores the full-screen window
        send_swreset();
        repeat (6) @(negedge clk);
        check("swr_cmd_byte",   32'(cmd_byte),   32'd0);
        check("swr_wr_addr",    32'(fb_wr_addr), 32'd0);
        check("swr_wr_data",    32'(fb_wr_data), 32'd0);
        check("swr_sleep_out",  32'(sleep_out),  32'd0);

        // Partial byte dropped by deselect
        send_cmd(8'h2C);
        send_bits(1'b1, 8'hFF, 3);
        spi_csb = 1'b1;
        repeat (8) @(negedge clk);
        spi_csb = 1'b0;
        repeat (4) @(negedge clk);
        send_pixel(17'd0, 16'hABCD);
        drain("partial");

        // Command mid-pixel drops the pending high byte
        send_cmd(8'h2C);
        send_data(8'hAB);
        send_cmd(8'h2C);
        send_pixel(17'd0, 16'h1111);
        drain("midpixel_cmd");

        // rst in the middle of a pixel
        send_cmd(8'h11);
        send_cmd(8'h2C);
        send_data(8'h55);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_wr_ena",     32'(fb_wr_ena),  32'd0);
        check("rst2_wr_addr",    32'(fb_wr_addr), 32'd0);
        check("rst2_wr_data",    32'(fb_wr_data), 32'd0);
        check("rst2_cmd_byte",   32'(cmd_byte),   32'd0);
        check("rst2_sleep_out",  32'(sleep_out),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_cmd(8'h2C);
        send_pixel(17'd0, 16'h2222);
        drain("rst_midpixel");

        // CASET with xe = 256
        send_cmd(8'h2A);
        send_data(8'h00); send_data(8'h00); send_data(8'h01); send_data(8'h00);
        repeat (6) @(negedge clk);
`ifdef ILI9341_RX_BOUNDS_CHECK_EN
        check("bounds_error", 32'(error), 32'd1);
        send_cmd(8'h2C);
        send_pixel(17'd0, 16'h3333);
        send_pixel(17'd1, 16'h4444);
`else
        check("bounds_error", 32'(error), 32'd0);
        send_cmd(8'h2C);
        send_pixel(17'd0,   16'h3333);
        send_pixel(17'd240, 16'h4444);
`endif
        drain("bounds");
        send_swreset();
        repeat (6) @(negedge clk);
        check("swr_error", 32'(error), 32'd0);

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ili9341_spi_receiver.md
ILI9341_SPI_RECEIVER -- requirements
Module: ili9341_spi_receiver

Interface
REQ-001 SHALL have parameter DISPLAY_WIDTH, default 240, pixel columns.
REQ-002 SHALL have parameter DISPLAY_HEIGHT, default 320, pixel rows.
REQ-003 SHALL have parameter VRAM_L, default DISPLAY_WIDTH*DISPLAY_HEIGHT, framebuffer depth.
REQ-004 SHALL have one clock and a synchronous, active-high reset, ports named clk and rst.
REQ-005 Ports SHALL be:
- clk, in, 1, system clock
- rst, in, 1, sync active-high reset
- spi_csb, in, 1, chip select, active low
- spi_clk, in, 1, SPI clock, mode 0
- spi_mosi, in, 1, serial data, MSB first
- data_commandb, in, 1, 1 = data, 0 = command
- spi_miso, out, 1, tied 0
- fb_wr_ena, out, 1, framebuffer write strobe
- fb_wr_addr, out, $clog2(VRAM_L), y*DISPLAY_WIDTH+x
- fb_wr_data, out, 16, RGB565 pixel
- cmd_valid, out, 1, one-cycle pulse per command byte
- cmd_byte, out, 8, last command opcode
- sleep_out, out, 1, SLPOUT received
- display_on, out, 1, DISPON received
- error, out, 1, sticky window error (see REQ-021)

Function
REQ-006 SHALL pass spi_csb, spi_clk, spi_mosi and data_commandb through 2-FF synchronizers, then detect the spi_clk rising edge; spi_clk SHALL be at most clk/4.
REQ-007 SHALL shift spi_mosi on each synchronized rising edge while spi_csb is low; after 8 bits it SHALL emit a byte and latch data_commandb as sampled with bit 0.
REQ-008 Byte-to-consumer latency SHALL be 3 clk cycles after the spi_clk rising edge of bit 0.
REQ-009 When spi_csb goes high mid-byte, the partial byte SHALL be discarded and the bit count cleared; command context SHALL be kept.
REQ-010 A command byte SHALL pulse cmd_valid for 1 cycle, update cmd_byte, and move the FSM per REQ-011.
REQ-011 FSM states SHALL be S_IDLE, S_CASET, S_PASET, S_RAMWR, S_IGNORE.
- 0x2A goes to S_CASET; 0x2B to S_PASET; 0x2C to S_RAMWR.
- 0x11 sets sleep_out; 0x29 sets display_on; 0x28 clears display_on; 0x01 performs the software reset in REQ-018.
- All other opcodes go to S_IGNORE.
REQ-012 In S_CASET, 4 data bytes SHALL set xs = {b0,b1} and xe = {b2,b3}; further data bytes SHALL be ignored.
REQ-013 In S_PASET, 4 data bytes SHALL set ys and ye in the same way.
REQ-014 Entering S_RAMWR SHALL set the pointer to (xs,ys).
REQ-015 In S_RAMWR, pixels SHALL be 2 bytes, high byte first; fb_wr_ena SHALL pulse 1 cycle after the low byte is emitted, with the current address and data.
REQ-016 Pointer advance after each pixel: if x == xe then x = xs and y advances, else x increments; if y == ye when y would advance, y = ys (wrap to window start).
REQ-017 A command byte arriving mid-pixel SHALL drop the pending high byte.

Reset
REQ-018 rst and SWRESET (0x01) SHALL set:
- FSM to S_IDLE; window to xs=0, xe=DISPLAY_WIDTH-1, ys=0, ye=DISPLAY_HEIGHT-1
- all outputs to 0 (cmd_byte, fb_wr_addr, fb_wr_data, error included)
- bit count to 0
REQ-019 SWRESET SHALL NOT clear the synchronizer flops.
REQ-020 rst SHALL take priority over any simultaneous byte or write.

Configuration
REQ-021 With ILI9341_RX_BOUNDS_CHECK_EN defined:
- A completed CASET/PASET with end >= dimension, or start > end, SHALL set error (sticky until reset) and leave the prior window unchanged.
- Without the macro, values SHALL be truncated to the pointer width and accepted unchecked; error SHALL be constant 0.

Structure
REQ-022 Opcode values and ILI9341_color_t SHALL come from the shared ili9341_defines package; the FSM state enum SHALL be local.
REQ-023 Synchronization and deserialization SHALL be the sub-module spi_byte_receiver, with outputs byte_valid, byte_data[7:0], byte_dc.

Verification
REQ-024 Bytes 0x11, 0x29 (dc=0) -> two cmd_valid pulses; sleep_out=1; display_on=1; cmd_byte=0x29.
REQ-025 CASET 0,10,0,11; PASET 0,5,0,6; RAMWR; pixels F800,07E0,001F,FFFF,1234 -> addresses 1210,1211,1450,1451,1210 with matching data.
REQ-026 Byte 0x2C, then 3 MOSI bits, then spi_csb high, then full pixel ABCD -> exactly one write of 0xABCD to address 0.
REQ-027 RAMWR, byte 0xAB, then command 0x2C, then pixel 0x1111 -> one write of 0x1111 to address 0.
REQ-028 With ILI9341_RX_BOUNDS_CHECK_EN: CASET 0,0,0x01,0x00 (xe=256) -> error=1, window unchanged; then SWRESET -> error=0.
REQ-029 rst asserted mid-pixel -> all outputs 0 on the next cycle; the next RAMWR writes to address 0.
